// File: rtl/pusch_fft_pkg.sv
// Shared definitions for the PUSCH FFT front end: default burst geometry and
// the burst controller state encoding.
package pusch_fft_pkg;

   localparam int unsigned DefWidth      = 18;
   localparam int unsigned DefN          = 64;
   localparam int unsigned DefCp0Len     = 20;
   localparam int unsigned DefCpLen      = 16;
   localparam int unsigned DefSymPerSlot = 14;

   typedef enum logic [2:0] {
      StIdle,
      StCpSkip,
      StLoad,
      StDrain,
      StGap
   } burst_state_e;

endpackage

// File: rtl/fft_burst_ctrl.sv
// Slot-level burst controller: strips cyclic prefixes, streams N samples per
// symbol into the reorder buffer, then waits for the buffer to drain.
module fft_burst_ctrl
   import pusch_fft_pkg::*;
#(
   parameter int unsigned WIDTH        = DefWidth,
   parameter int unsigned N            = DefN,
   parameter int unsigned CP0_LEN      = DefCp0Len,
   parameter int unsigned CP_LEN       = DefCpLen,
   parameter int unsigned SYM_PER_SLOT = DefSymPerSlot
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] s_re,
   input  logic [WIDTH-1:0] s_im,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] di_re,
   output logic [WIDTH-1:0] di_im,
   output logic             di_en,
   input  logic             ro_do_en,
   output logic [3:0]       sym_idx,
   output logic             busy,
   output logic             slot_done,
   output logic             err_gap,
   output logic             err_spur,
   output logic             err_tmo
);

   localparam int unsigned CntW  = $clog2(N) + 1;
   localparam int unsigned CpMax = (CP0_LEN > CP_LEN) ? CP0_LEN : CP_LEN;
   localparam int unsigned CpW   = $clog2(CpMax + 1);
   localparam int unsigned TmoW  = $clog2(2 * N) + 1;

   localparam logic [CntW-1:0] NLast   = CntW'(N - 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(2 * N - 1);
   localparam logic [CpW-1:0]  Cp0     = CpW'(CP0_LEN);
   localparam logic [CpW-1:0]  Cp      = CpW'(CP_LEN);
   localparam logic [3:0]      LastSym = 4'(SYM_PER_SLOT - 1);

   burst_state_e     state_q, state_d;
   logic [3:0]       sym_q, sym_d;
   logic [CpW-1:0]   cp_q, cp_d;
   logic [CntW-1:0]  smp_q, smp_d;
   logic [TmoW-1:0]  tmo_q, tmo_d;
   logic [WIDTH-1:0] re_q, re_d, im_q, im_d;
   logic             den_q, den_d;
   logic             gap_q, gap_d, spur_q, spur_d, tmo_err_q, tmo_err_d;
   logic             accept, clr_err;

   assign s_ready = (state_q == StCpSkip) || (state_q == StLoad);
   assign accept  = s_valid && s_ready;

   always_comb begin
      state_d   = state_q;
      sym_d     = sym_q;
      cp_d      = cp_q;
      smp_d     = smp_q;
      tmo_d     = tmo_q;
      re_d      = '0;
      im_d      = '0;
      den_d     = 1'b0;
      clr_err   = 1'b0;
      gap_d     = gap_q;
      tmo_err_d = tmo_err_q;
      slot_done = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StCpSkip;
               sym_d   = '0;
               cp_d    = Cp0;
               smp_d   = '0;
               tmo_d   = '0;
               clr_err = 1'b1;
            end
         end
         StCpSkip: begin
            if (accept) begin
               if (cp_q <= CpW'(1)) begin
                  state_d = StLoad;
                  cp_d    = '0;
                  smp_d   = '0;
               end else begin
                  cp_d = cp_q - CpW'(1);
               end
            end
         end
         StLoad: begin
            if (accept) begin
               re_d  = s_re;
               im_d  = s_im;
               den_d = 1'b1;
               smp_d = smp_q + CntW'(1);
               if (smp_q == NLast) begin
                  state_d = StDrain;
                  smp_d   = '0;
                  tmo_d   = '0;
               end
            end else if (smp_q != '0) begin
               // Upstream stalled mid-symbol: drain what was written.
               gap_d   = 1'b1;
               state_d = StDrain;
               smp_d   = '0;
               tmo_d   = '0;
            end
         end
         StDrain: begin
            if (ro_do_en) begin
               tmo_d = '0;
               smp_d = smp_q + CntW'(1);
               if (smp_q == NLast) begin
                  state_d = StGap;
                  smp_d   = '0;
               end
            end else if (tmo_q == TmoLast) begin
               tmo_err_d = 1'b1;
               state_d   = StIdle;
               sym_d     = '0;
               smp_d     = '0;
               tmo_d     = '0;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StGap: begin
            if (sym_q == LastSym) begin
               state_d   = StIdle;
               sym_d     = '0;
               slot_done = 1'b1;
            end else begin
               state_d = StCpSkip;
               sym_d   = sym_q + 4'd1;
               cp_d    = Cp;
            end
         end
         default: state_d = StIdle;
      endcase

      if (clr_err) begin
         gap_d     = 1'b0;
         tmo_err_d = 1'b0;
      end
      spur_d = (clr_err ? 1'b0 : spur_q) | (ro_do_en && (state_q != StDrain));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         sym_q     <= '0;
         cp_q      <= '0;
         smp_q     <= '0;
         tmo_q     <= '0;
         re_q      <= '0;
         im_q      <= '0;
         den_q     <= 1'b0;
         gap_q     <= 1'b0;
         spur_q    <= 1'b0;
         tmo_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sym_q     <= sym_d;
         cp_q      <= cp_d;
         smp_q     <= smp_d;
         tmo_q     <= tmo_d;
         re_q      <= re_d;
         im_q      <= im_d;
         den_q     <= den_d;
         gap_q     <= gap_d;
         spur_q    <= spur_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign di_re    = re_q;
   assign di_im    = im_q;
   assign di_en    = den_q;
   assign sym_idx  = sym_q;
   assign busy     = (state_q != StIdle);
   assign err_gap  = gap_q;
   assign err_spur = spur_q;
   assign err_tmo  = tmo_err_q;

endmodule

// File: doc/fft_burst_ctrl.md
FFT_BURST_CTRL -- requirements
Module: fft_burst_ctrl

Interface
REQ-001 Parameter WIDTH, default 18: sample component width, signed two's complement.
REQ-002 Parameter N, default 64: FFT size / reorder burst length; power of two, 8..256.
REQ-003 Parameter CP0_LEN, default 20: cyclic-prefix samples discarded before symbol 0 of a slot.
REQ-004 Parameter CP_LEN, default 16: cyclic-prefix samples discarded before symbols 1..SYM_PER_SLOT-1.
REQ-005 Parameter SYM_PER_SLOT, default 14: symbols per slot, 1..15.
REQ-006 One clock; reset is asynchronous and active-low. Ports follow, clock and reset first:
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle pulse; begins a slot when idle.
REQ-010 s_re, s_im  in  WIDTH each  upstream time-domain sample.
REQ-011 s_valid  in  1  upstream sample valid.
REQ-012 s_ready  out  1  sample accepted when s_valid && s_ready.
REQ-013 di_re, di_im  out  WIDTH each  sample to reorder buffer.
REQ-014 di_en  out  1  write strobe to reorder buffer.
REQ-015 ro_do_en  in  1  reorder buffer output strobe (monitored only).
REQ-016 sym_idx  out  4  index of symbol currently loading/draining.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 slot_done  out  1  one-cycle pulse after the last symbol drains.
REQ-019 err_gap, err_spur, err_tmo  out  1 each  sticky error flags.

Function
REQ-020 States: IDLE, CP_SKIP, LOAD, DRAIN, GAP.
REQ-021 IDLE: s_ready=0, di_en=0; start -> CP_SKIP with sym_idx=0, cp counter loaded with CP0_LEN; start outside IDLE is ignored.
REQ-022 CP_SKIP: s_ready=1; each accepted sample is discarded; after CP0_LEN (sym 0) or CP_LEN (others) accepted samples -> LOAD.
REQ-023 LOAD: s_ready=1; each accepted sample is registered to di_re/di_im with di_en=1 on the next cycle (latency 1); after N accepted samples -> DRAIN.
REQ-024 di_re/di_im hold zero whenever di_en=0.
REQ-025 s_valid low during LOAD after at least one LOAD sample: err_gap set, -> DRAIN immediately (buffer drains regardless).
REQ-026 DRAIN: s_ready=0, di_en=0; counts ro_do_en pulses; after N pulses -> GAP.
REQ-027 DRAIN timeout: no ro_do_en for 2*N consecutive cycles sets err_tmo, -> IDLE, sym_idx=0, no slot_done.
REQ-028 GAP: exactly one cycle, s_ready=0, di_en=0; then if sym_idx==SYM_PER_SLOT-1 -> IDLE with slot_done=1 that cycle, else sym_idx+1 and -> CP_SKIP with CP_LEN.
REQ-029 ro_do_en high in any state other than DRAIN sets err_spur; state unaffected.
REQ-030 Counters sized $clog2(N)+1 bits; no wrap reliance; CP counter sized for max(CP0_LEN,CP_LEN).
REQ-031 Error flags clear only on reset or on start accepted in IDLE.

Reset
REQ-032 On rst low: state IDLE; s_ready, di_en, di_re, di_im, sym_idx, busy, slot_done, err flags all 0; all counters 0.
REQ-033 Reset asserted mid-slot aborts immediately; no slot_done; next start after release begins at sym 0 with CP0_LEN.

Structure
REQ-034 State encoding and default parameters (N, CP0_LEN, CP_LEN, SYM_PER_SLOT) live in shared package pusch_fft_pkg.
REQ-035 Single module; no sub-modules; flat FSM plus three counters (cp, sample, drain/timeout).

Verification
REQ-036 Reset then start, continuous s_valid, model reorder returning 64 ro_do_en after di_en falls -> 14 bursts of exactly 64 di_en, first discards 20 samples, rest 16; slot_done once, 14*(64+CP+64+1)+4 cycles total within +/-2.
REQ-037 Sample sequence 0,1,2,... -> di_re over symbol 0 equals 20..83, symbol 1 equals 100..163.
REQ-038 s_valid low for 3 cycles at LOAD sample 30 -> err_gap=1, DRAIN entered next cycle, sym_idx advances after drain.
REQ-039 Reorder model silent in DRAIN -> err_tmo=1 after 128 cycles, busy=0, slot_done never pulses.
REQ-040 ro_do_en pulse injected during CP_SKIP -> err_spur=1, burst timing unchanged; start then clears it.
REQ-041 rst low during symbol 5 LOAD -> all outputs 0 next cycle; new start restarts with 20-sample CP skip, sym_idx=0.
